parking_slot_manager: RTL and testbench

Sequential controller that owns the 8-slot parking occupancy bitmap and serialises access to it. It arbitrates slot requests from two entry gates and release requests from one exit gate. Entry gates get a round-robin grant and the lowest free slot; the exit gate frees a one-hot slot. It sits between the gate/sensor front-end and the capacity-update datapath, and its occupancy output is the lot-wide `parking_capacity` view.

---
 rtl/parking_slot_manager_if.sv | 63 ++++++
 rtl/parking_slot_manager.sv | 191 +++++++++++++++++++
 tb/tb_parking_slot_manager.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/parking_slot_manager_if.sv
// Gate/sensor front-end <-> parking slot manager bundle.
//   master : front-end side, drives the requests, observes responses and lot status
//   slave  : manager side, samples the requests, drives responses and lot status
// Signals:
//   entry_req[1:0]  level slot request per entry gate, held until ack/nack
//   exit_req        level release request, held until exit_ack/exit_err
//   exit_slot[7:0]  one-hot slot being vacated, valid with exit_req
//   entry_ack[1:0]  one-cycle grant pulse per gate
//   entry_nack[1:0] one-cycle lot-full refusal pulse per gate
//   grant_slot[7:0] one-hot granted slot, non-zero only alongside entry_ack
//   exit_ack        one-cycle release pulse
//   exit_err        one-cycle pulse for a malformed or already-free exit slot
//   occupancy[7:0]  lot bitmap, bit i set = slot i taken
//   free_count[3:0] number of free slots, 0..8
//   full / empty    occupancy all ones / all zeros
//   busy            a transaction is in progress
interface parking_slot_manager_if;
  logic [1:0] entry_req;
  logic       exit_req;
  logic [7:0] exit_slot;
  logic [1:0] entry_ack;
  logic [1:0] entry_nack;
  logic [7:0] grant_slot;
  logic       exit_ack;
  logic       exit_err;
  logic [7:0] occupancy;
  logic [3:0] free_count;
  logic       full;
  logic       empty;
  logic       busy;

  modport master (
    output entry_req,
    output exit_req,
    output exit_slot,
    input  entry_ack,
    input  entry_nack,
    input  grant_slot,
    input  exit_ack,
    input  exit_err,
    input  occupancy,
    input  free_count,
    input  full,
    input  empty,
    input  busy
  );

  modport slave (
    input  entry_req,
    input  exit_req,
    input  exit_slot,
    output entry_ack,
    output entry_nack,
    output grant_slot,
    output exit_ack,
    output exit_err,
    output occupancy,
    output free_count,
    output full,
    output empty,
    output busy
  );
endinterface

// File: rtl/parking_slot_manager.sv
// Parking slot manager: owns the 8-slot occupancy bitmap and serialises access to it.
// Two entry gates are arbitrated round-robin and receive the lowest free slot; one exit
// gate releases a one-hot slot. Each transaction takes IDLE -> SERVE -> DONE, with the
// response pulse visible during DONE. All outputs are registered.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset, reloads INIT_OCCUPANCY
//   bus    parking_slot_manager_if.slave (requests in, responses and lot status out)
module parking_slot_manager #(
  parameter logic [7:0] INIT_OCCUPANCY = 8'h00
) (
  input logic                   clk,
  input logic                   reset,
  parking_slot_manager_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StServe, StDone} state_e;
  typedef enum logic {OpEntry, OpExit} op_e;

  function automatic logic [3:0] count_free(input logic [7:0] occ);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, ~occ[i]};
    end
    return n;
  endfunction

  state_e     state_q, state_d;
  op_e        op_q, op_d;
  logic       gate_q, gate_d;
  logic [7:0] slot_q, slot_d;
  logic       last_gate_q, last_gate_d;
  logic [7:0] occ_q, occ_d;
  logic [3:0] free_q, free_d;
  logic       full_q, full_d;
  logic       empty_q, empty_d;
  logic       busy_q, busy_d;
  logic [1:0] entry_ack_q, entry_ack_d;
  logic [1:0] entry_nack_q, entry_nack_d;
  logic [7:0] grant_q, grant_d;
  logic       exit_ack_q, exit_ack_d;
  logic       exit_err_q, exit_err_d;

  logic       pick_gate;
  logic [7:0] free_slot;
  logic       slot_found;
  logic       slot_onehot;
  logic       exit_valid;

  // Single requester wins outright; on a tie the gate not served last time wins.
  assign pick_gate = (bus.entry_req == 2'b11) ? ~last_gate_q : bus.entry_req[1];

  // Lowest-index free slot as a one-hot mask, zero when the lot is full.
  always_comb begin
    free_slot  = '0;
    slot_found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!occ_q[i] && !slot_found) begin
        free_slot[i] = 1'b1;
        slot_found   = 1'b1;
      end
    end
  end

  assign slot_onehot = (slot_q != 8'h00) && ((slot_q & (slot_q - 8'h01)) == 8'h00);
  assign exit_valid  = slot_onehot && ((slot_q & occ_q) != 8'h00);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.exit_req || (bus.entry_req != 2'b00)) begin
          state_d = StServe;
        end
      end
      StServe: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output / datapath next values; pulses default low so DONE clears them.
  always_comb begin
    op_d         = op_q;
    gate_d       = gate_q;
    slot_d       = slot_q;
    last_gate_d  = last_gate_q;
    occ_d        = occ_q;
    entry_ack_d  = '0;
    entry_nack_d = '0;
    grant_d      = '0;
    exit_ack_d   = 1'b0;
    exit_err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.exit_req) begin
          op_d   = OpExit;
          slot_d = bus.exit_slot;
        end else if (bus.entry_req != 2'b00) begin
          op_d   = OpEntry;
          gate_d = pick_gate;
        end
      end
      StServe: begin
        if (op_q == OpExit) begin
          if (exit_valid) begin
            occ_d      = occ_q & ~slot_q;
            exit_ack_d = 1'b1;
          end else begin
            exit_err_d = 1'b1;
          end
        end else begin
          last_gate_d = gate_q;
          if (full_q) begin
            entry_nack_d[gate_q] = 1'b1;
          end else begin
            occ_d               = occ_q | free_slot;
            grant_d             = free_slot;
            entry_ack_d[gate_q] = 1'b1;
          end
        end
      end
      StDone: begin
      end
      default: begin
      end
    endcase
    // Status flags are derived from the same next occupancy so they never disagree.
    free_d  = count_free(occ_d);
    full_d  = (occ_d == 8'hFF);
    empty_d = (occ_d == 8'h00);
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q         <= OpEntry;
      gate_q       <= 1'b0;
      slot_q       <= '0;
      last_gate_q  <= 1'b1;
      occ_q        <= INIT_OCCUPANCY;
      free_q       <= count_free(INIT_OCCUPANCY);
      full_q       <= (INIT_OCCUPANCY == 8'hFF);
      empty_q      <= (INIT_OCCUPANCY == 8'h00);
      busy_q       <= 1'b0;
      entry_ack_q  <= '0;
      entry_nack_q <= '0;
      grant_q      <= '0;
      exit_ack_q   <= 1'b0;
      exit_err_q   <= 1'b0;
    end else begin
      op_q         <= op_d;
      gate_q       <= gate_d;
      slot_q       <= slot_d;
      last_gate_q  <= last_gate_d;
      occ_q        <= occ_d;
      free_q       <= free_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      busy_q       <= busy_d;
      entry_ack_q  <= entry_ack_d;
      entry_nack_q <= entry_nack_d;
      grant_q      <= grant_d;
      exit_ack_q   <= exit_ack_d;
      exit_err_q   <= exit_err_d;
    end
  end

  assign bus.entry_ack  = entry_ack_q;
  assign bus.entry_nack = entry_nack_q;
  assign bus.grant_slot = grant_q;
  assign bus.exit_ack   = exit_ack_q;
  assign bus.exit_err   = exit_err_q;
  assign bus.occupancy  = occ_q;
  assign bus.free_count = free_q;
  assign bus.full       = full_q;
  assign bus.empty      = empty_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_parking_slot_manager.sv
// Self-checking bench for parking_slot_manager: a table of transactions applied in order
// from reset, expected responses queued when driven and compared when the pulse appears,
// plus hand-written reset-during-transaction sequences.
module tb_parking_slot_manager;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  parking_slot_manager_if bus ();

  parking_slot_manager #(
    .INIT_OCCUPANCY(8'h00)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [1:0] ereq;
    logic       xreq;
    logic [7:0] xslot;
    logic [1:0] keep;
    logic [1:0] ack;
    logic [1:0] nack;
    logic [7:0] grant;
    logic       xack;
    logic       xerr;
    logic [7:0] occ;
  } vec_t;

  typedef struct {
    logic [1:0] ack;
    logic [1:0] nack;
    logic [7:0] grant;
    logic       xack;
    logic       xerr;
    logic [7:0] occ;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t vecs[21];

  function automatic vec_t mk(input logic [1:0] ereq, input logic xreq, input logic [7:0] xslot,
                              input logic [1:0] keep, input logic [1:0] ack,
                              input logic [1:0] nack, input logic [7:0] grant, input logic xack,
                              input logic xerr, input logic [7:0] occ);
    vec_t v;
    v.ereq = ereq; v.xreq = xreq; v.xslot = xslot; v.keep = keep;
    v.ack = ack; v.nack = nack; v.grant = grant; v.xack = xack; v.xerr = xerr; v.occ = occ;
    return v;
  endfunction

  function automatic logic [7:0] zeros_in(input logic [7:0] occ);
    logic [7:0] n;
    n = 0;
    for (int i = 0; i < 8; i++) if (occ[i] == 1'b0) n++;
    return n;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_status(input string tag, input logic [7:0] occ);
    check({tag, " occupancy"}, bus.occupancy, occ);
    check({tag, " free_count"}, {4'h0, bus.free_count}, zeros_in(occ));
    check({tag, " full"}, {7'h0, bus.full}, {7'h0, occ == 8'hFF});
    check({tag, " empty"}, {7'h0, bus.empty}, {7'h0, occ == 8'h00});
  endtask

  task automatic check_idle(input string tag);
    check({tag, " entry_ack idle"}, {6'h0, bus.entry_ack}, 8'h00);
    check({tag, " entry_nack idle"}, {6'h0, bus.entry_nack}, 8'h00);
    check({tag, " grant_slot idle"}, bus.grant_slot, 8'h00);
    check({tag, " exit_ack idle"}, {7'h0, bus.exit_ack}, 8'h00);
    check({tag, " exit_err idle"}, {7'h0, bus.exit_err}, 8'h00);
    check({tag, " busy idle"}, {7'h0, bus.busy}, 8'h00);
  endtask

  task automatic wait_resp(output logic got);
    got = 1'b0;
    for (int c = 0; c < 12 && !got; c++) begin
      @(negedge clk);
      if (bus.entry_ack != 0 || bus.entry_nack != 0 || bus.exit_ack || bus.exit_err) got = 1'b1;
    end
  endtask

  // Pops the oldest expectation and compares it against the pulse now on the bus.
  task automatic check_resp(input string tag, input logic got);
    exp_t e;
    e = sb.pop_front();
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s response timeout actual=none required=pulse", tag);
      return;
    end
    check({tag, " entry_ack"}, {6'h0, bus.entry_ack}, {6'h0, e.ack});
    check({tag, " entry_nack"}, {6'h0, bus.entry_nack}, {6'h0, e.nack});
    check({tag, " grant_slot"}, bus.grant_slot, e.grant);
    check({tag, " exit_ack"}, {7'h0, bus.exit_ack}, {7'h0, e.xack});
    check({tag, " exit_err"}, {7'h0, bus.exit_err}, {7'h0, e.xerr});
    check({tag, " busy"}, {7'h0, bus.busy}, 8'h01);
    check_status(tag, e.occ);
  endtask

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.ack = v.ack; e.nack = v.nack; e.grant = v.grant;
    e.xack = v.xack; e.xerr = v.xerr; e.occ = v.occ;
    sb.push_back(e);
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    logic got;
    push_exp(v);
    bus.entry_req = v.ereq;
    bus.exit_req  = v.xreq;
    bus.exit_slot = v.xslot;
    wait_resp(got);
    check_resp(tag, got);
    @(posedge clk);
    #1;
    bus.entry_req = v.keep;
    bus.exit_req  = 1'b0;
    bus.exit_slot = 8'h00;
    @(negedge clk);
    check_idle(tag);
  endtask

  initial begin
    logic got;
    //              ereq   xr    xslot  keep   ack    nack   grant  xa    xe    occ
    vecs[0]  = mk(2'b01, 1'b0, 8'h00, 2'b00, 2'b01, 2'b00, 8'h01, 1'b0, 1'b0, 8'h01);
    vecs[1]  = mk(2'b10, 1'b0, 8'h00, 2'b00, 2'b10, 2'b00, 8'h02, 1'b0, 1'b0, 8'h03);
    vecs[2]  = mk(2'b01, 1'b0, 8'h00, 2'b00, 2'b01, 2'b00, 8'h04, 1'b0, 1'b0, 8'h07);
    vecs[3]  = mk(2'b10, 1'b0, 8'h00, 2'b00, 2'b10, 2'b00, 8'h08, 1'b0, 1'b0, 8'h0F);
    vecs[4]  = mk(2'b00, 1'b1, 8'h04, 2'b00, 2'b00, 2'b00, 8'h00, 1'b1, 1'b0, 8'h0B);
    vecs[5]  = mk(2'b11, 1'b0, 8'h00, 2'b10, 2'b01, 2'b00, 8'h04, 1'b0, 1'b0, 8'h0F);
    vecs[6]  = mk(2'b10, 1'b0, 8'h00, 2'b00, 2'b10, 2'b00, 8'h10, 1'b0, 1'b0, 8'h1F);
    vecs[7]  = mk(2'b00, 1'b1, 8'h10, 2'b00, 2'b00, 2'b00, 8'h00, 1'b1, 1'b0, 8'h0F);
    vecs[8]  = mk(2'b01, 1'b1, 8'h04, 2'b01, 2'b00, 2'b00, 8'h00, 1'b1, 1'b0, 8'h0B);
    vecs[9]  = mk(2'b01, 1'b0, 8'h00, 2'b00, 2'b01, 2'b00, 8'h04, 1'b0, 1'b0, 8'h0F);
    vecs[10] = mk(2'b00, 1'b1, 8'h20, 2'b00, 2'b00, 2'b00, 8'h00, 1'b0, 1'b1, 8'h0F);
    vecs[11] = mk(2'b00, 1'b1, 8'h03, 2'b00, 2'b00, 2'b00, 8'h00, 1'b0, 1'b1, 8'h0F);
    vecs[12] = mk(2'b00, 1'b1, 8'h00, 2'b00, 2'b00, 2'b00, 8'h00, 1'b0, 1'b1, 8'h0F);
    vecs[13] = mk(2'b01, 1'b0, 8'h00, 2'b00, 2'b01, 2'b00, 8'h10, 1'b0, 1'b0, 8'h1F);
    vecs[14] = mk(2'b10, 1'b0, 8'h00, 2'b00, 2'b10, 2'b00, 8'h20, 1'b0, 1'b0, 8'h3F);
    vecs[15] = mk(2'b01, 1'b0, 8'h00, 2'b00, 2'b01, 2'b00, 8'h40, 1'b0, 1'b0, 8'h7F);
    vecs[16] = mk(2'b10, 1'b0, 8'h00, 2'b00, 2'b10, 2'b00, 8'h80, 1'b0, 1'b0, 8'hFF);
    vecs[17] = mk(2'b10, 1'b0, 8'h00, 2'b00, 2'b00, 2'b10, 8'h00, 1'b0, 1'b0, 8'hFF);
    vecs[18] = mk(2'b01, 1'b0, 8'h00, 2'b00, 2'b00, 2'b01, 8'h00, 1'b0, 1'b0, 8'hFF);
    // Tie after gate 0 was refused last: gate 1 takes the turn.
    vecs[19] = mk(2'b11, 1'b0, 8'h00, 2'b00, 2'b00, 2'b10, 8'h00, 1'b0, 1'b0, 8'hFF);
    vecs[20] = mk(2'b00, 1'b1, 8'h01, 2'b00, 2'b00, 2'b00, 8'h00, 1'b1, 1'b0, 8'hFE);

    reset         = 1'b1;
    bus.entry_req = 2'b00;
    bus.exit_req  = 1'b0;
    bus.exit_slot = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_idle("reset");
    check_status("reset", 8'h00);

    for (int i = 0; i < 21; i++) begin
      run_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset while DONE of a grant is showing: no further pulse, bitmap back to init.
    push_exp(mk(2'b01, 1'b0, 8'h00, 2'b00, 2'b01, 2'b00, 8'h01, 1'b0, 1'b0, 8'hFF));
    bus.entry_req = 2'b01;
    wait_resp(got);
    check_resp("rst_done grant", got);
    reset         = 1'b1;
    bus.entry_req = 2'b00;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_idle("rst_done");
    check_status("rst_done", 8'h00);

    // Reset while SERVE: the pending grant is discarded.
    bus.entry_req = 2'b10;
    @(posedge clk);
    #1;
    reset         = 1'b1;
    bus.entry_req = 2'b00;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_idle("rst_serve");
    check_status("rst_serve", 8'h00);
    @(negedge clk);
    check_idle("rst_serve later");

    // After reset gate 0 wins the first tie.
    run_txn(mk(2'b11, 1'b0, 8'h00, 2'b00, 2'b01, 2'b00, 8'h01, 1'b0, 1'b0, 8'h01), "tie");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
